// File: rtl/lowf_queue_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// lowf_pkg
// Shared types and sizing for the low-frequency band sample queue controller.
//   DEPTH  : RAM word count (power of two)
//   ADDR_W : RAM address width, log2(DEPTH)
//   TAPS   : samples streamed per read burst (TAPS <= DEPTH-2)
//   DECIM  : decimation ratio, one accepted sample per DECIM pulses
//   SMPL_W : sample width
// ----------------------------------------------------------------------------
package lowf_pkg;

   localparam int DEPTH  = 1024;
   localparam int ADDR_W = 10;
   localparam int TAPS   = 1021;
   localparam int DECIM  = 2;
   localparam int SMPL_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      WAIT = 2'd2,
      READ = 2'd3
   } lowf_state_t;

endpackage

// File: rtl/lowf_queue_ctrl_if.sv
// ----------------------------------------------------------------------------
// lowf_queue_ctrl_if
// Bundles the sample input, RAM port and FIR-side signals of the controller.
//   slave  : the controller (consumes wrt_smpl/new_smpl/rdata, drives the rest)
//   master : the surrounding parent / RAM / sample source
// Signals:
//   wrt_smpl, new_smpl      incoming sample strobe and data
//   we, waddr, wdata        RAM write port
//   raddr, rdata            RAM read port (rdata one cycle after raddr)
//   smpl_out, smpl_vld      burst sample stream to the FIR
//   sequencing, burst_done  burst in progress / last-sample pulse
//   full, overrun           sticky status flags
// ----------------------------------------------------------------------------
interface lowf_queue_ctrl_if;
   import lowf_pkg::*;

   logic              wrt_smpl;
   logic [SMPL_W-1:0] new_smpl;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [SMPL_W-1:0] wdata;
   logic [ADDR_W-1:0] raddr;
   logic [SMPL_W-1:0] rdata;
   logic [SMPL_W-1:0] smpl_out;
   logic              smpl_vld;
   logic              sequencing;
   logic              burst_done;
   logic              full;
   logic              overrun;

   modport slave (
      input  wrt_smpl, new_smpl, rdata,
      output we, waddr, wdata, raddr, smpl_out, smpl_vld,
             sequencing, burst_done, full, overrun
   );

   modport master (
      output wrt_smpl, new_smpl, rdata,
      input  we, waddr, wdata, raddr, smpl_out, smpl_vld,
             sequencing, burst_done, full, overrun
   );

endinterface

// File: rtl/lowf_queue_ctrl_rd_seq.sv
// ----------------------------------------------------------------------------
// lowf_rd_seq
// Read-burst address generator. A start pulse loads the oldest address; the
// next TAPS cycles present consecutive (wrapping) read addresses. Valid and
// done are delayed one cycle to line up with the registered RAM read data.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         launch a burst (must not be asserted while addresses issue)
//   oldest_i        first read address of the burst
//   raddr_o         RAM read address, holds its last value between bursts
//   smpl_vld_o      read data for the burst is on rdata this cycle
//   burst_done_o    pulse with the final smpl_vld_o of a burst
//   sequencing_o    address issue or final data still pending
//   last_addr_o     the final address of the burst is on raddr_o this cycle
// ----------------------------------------------------------------------------
module lowf_rd_seq
   import lowf_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] oldest_i,
   output logic [ADDR_W-1:0] raddr_o,
   output logic              smpl_vld_o,
   output logic              burst_done_o,
   output logic              sequencing_o,
   output logic              last_addr_o
);

   localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(TAPS - 1);

   logic              active_q, active_d;
   logic [ADDR_W-1:0] raddr_q,  raddr_d;
   logic [ADDR_W-1:0] rcnt_q,   rcnt_d;   // addresses still to issue after this one
   logic              vld_q;
   logic              done_q;

   always_comb begin
      active_d = active_q;
      raddr_d  = raddr_q;
      rcnt_d   = rcnt_q;
      if (start_i) begin
         active_d = 1'b1;
         raddr_d  = oldest_i;
         rcnt_d   = LAST_CNT;
      end else if (active_q) begin
         if (rcnt_q == '0) begin
            active_d = 1'b0;
         end else begin
            raddr_d = raddr_q + ADDR_W'(1);
            rcnt_d  = rcnt_q - ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= 1'b0;
         raddr_q  <= '0;
         rcnt_q   <= '0;
         vld_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         active_q <= active_d;
         raddr_q  <= raddr_d;
         rcnt_q   <= rcnt_d;
         vld_q    <= active_q;
         done_q   <= active_q && (rcnt_q == '0);
      end
   end

   assign raddr_o      = raddr_q;
   assign smpl_vld_o   = vld_q;
   assign burst_done_o = done_q;
   assign sequencing_o = active_q | vld_q;
   assign last_addr_o  = active_q && (rcnt_q == '0);

endmodule

// File: rtl/lowf_queue_ctrl.sv
// ----------------------------------------------------------------------------
// lowf_queue_ctrl
// Sequencer for the low-band sample queue. Decimates wrt_smpl pulses, writes
// accepted samples into a circular RAM buffer and, once TAPS samples are held,
// streams the TAPS most recent samples (oldest first) after every accepted
// sample. An accepted sample arriving while a burst issues addresses is still
// written but only raises the sticky overrun flag.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  lowf_queue_ctrl_if.slave: sample input, RAM ports, FIR stream, flags
// ----------------------------------------------------------------------------
module lowf_queue_ctrl
   import lowf_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   lowf_queue_ctrl_if.slave       bus
);

   localparam int                PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [PH_W-1:0]   PH_ACC = PH_W'(DECIM - 1);
   localparam logic [ADDR_W-1:0] TAPS_C = ADDR_W'(TAPS);

   lowf_state_t       state_q, state_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [ADDR_W-1:0] new_ptr_q, new_ptr_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              we_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [SMPL_W-1:0] wdata_q;
   logic              overrun_q;

   logic              accept;
   logic              full;
   logic              start;
   logic              set_ovr;
   logic              rd_last;
   logic              smpl_vld;
   logic [ADDR_W-1:0] oldest;

   assign accept = bus.wrt_smpl && (phase_q == PH_ACC);
   assign full   = (cnt_q == TAPS_C);
   // new_ptr_q already points past the sample written this cycle, so this is
   // the address of the oldest of the TAPS held samples; wraps naturally.
   assign oldest = new_ptr_q - TAPS_C;

   // ---------------- write path / decimation ----------------
   always_comb begin
      phase_d   = phase_q;
      new_ptr_d = new_ptr_q;
      cnt_d     = cnt_q;
      if (bus.wrt_smpl) begin
         phase_d = accept ? '0 : phase_q + PH_W'(1);
      end
      if (accept) begin
         new_ptr_d = new_ptr_q + ADDR_W'(1);
         if (cnt_q != TAPS_C) begin
            cnt_d = cnt_q + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q   <= '0;
         new_ptr_q <= '0;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         new_ptr_q <= new_ptr_d;
         cnt_q     <= cnt_d;
         we_q      <= accept;
         if (accept) begin
            waddr_q <= new_ptr_q;
            wdata_q <= bus.new_smpl;
         end
         if (set_ovr) begin
            overrun_q <= 1'b1;
         end
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   // Decisions are taken in the write cycle (we_q), when cnt_q already
   // reflects the new sample, so a burst's first address lands one cycle later.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (we_q) state_d = full ? READ : FILL;
         FILL: if (we_q && full) state_d = READ;
         WAIT: if (we_q) state_d = READ;
         READ: if (rd_last) state_d = WAIT;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      start   = 1'b0;
      set_ovr = 1'b0;
      if (we_q) begin
         if (state_q == READ) begin
            set_ovr = 1'b1;
         end else if (full) begin
            start = 1'b1;
         end
      end
   end

   lowf_rd_seq u_rd_seq (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .oldest_i     (oldest),
      .raddr_o      (bus.raddr),
      .smpl_vld_o   (smpl_vld),
      .burst_done_o (bus.burst_done),
      .sequencing_o (bus.sequencing),
      .last_addr_o  (rd_last)
   );

   assign bus.we       = we_q;
   assign bus.waddr    = waddr_q;
   assign bus.wdata    = wdata_q;
   assign bus.smpl_vld = smpl_vld;
   assign bus.smpl_out = smpl_vld ? bus.rdata : '0;
   assign bus.full     = full;
   assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_lowf_queue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lowf_queue_ctrl
// Scoreboard bench: the stimulus process pushes expected writes, burst start
// addresses and burst samples into queues; a monitor on the falling edge pops
// and compares whenever the DUT writes, starts a burst or presents smpl_vld.
// ----------------------------------------------------------------------------
module tb_lowf_queue_ctrl;
   import lowf_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   lowf_queue_ctrl_if bus ();

   lowf_queue_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // RAM model: registered read, one cycle latency
   logic [SMPL_W-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (bus.we) mem[bus.waddr] <= bus.wdata;
      bus.rdata <= mem[bus.raddr];
   end

   typedef struct { int addr; int data; } wr_t;
   typedef struct { int data; bit last; } rd_t;

   wr_t wq[$];
   rd_t rq[$];
   int  sq[$];

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0;

   int tb_phase;
   int n_acc;
   int hist [0:1100];

   task automatic check(input bit ok, input string name, input int act, input int exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // One wrt_smpl pulse followed by one idle cycle. For an accepted sample,
   // the expected write is queued, and when the queue holds TAPS samples and
   // a burst is expected, its start address and samples are queued too.
   task automatic send(input int v, input bit exp_burst);
      bus.new_smpl = 16'(v);
      bus.wrt_smpl = 1'b1;
      if (tb_phase == DECIM - 1) begin
         tb_phase = 0;
         n_acc++;
         hist[n_acc] = v;
         wq.push_back('{(n_acc - 1) % DEPTH, v});
         if (exp_burst && n_acc >= TAPS) begin
            sq.push_back((n_acc - TAPS) % DEPTH);
            for (int i = n_acc - TAPS + 1; i <= n_acc; i++)
               rq.push_back('{hist[i], i == n_acc});
         end
      end else begin
         tb_phase++;
      end
      @(posedge clk); #1;
      bus.wrt_smpl = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wait_done(input string name);
      int start_cnt;
      int t;
      start_cnt = done_cnt;
      t = 0;
      while (done_cnt == start_cnt && t < 1200) begin
         @(posedge clk); #1;
         t++;
      end
      check(done_cnt != start_cnt, name, t, 1200);
   endtask

   task automatic check_all_zero(input string name);
      int nz;
      nz = int'(bus.we != 0) + int'(bus.waddr != 0) + int'(bus.wdata != 0) +
           int'(bus.raddr != 0) + int'(bus.smpl_out != 0) + int'(bus.smpl_vld != 0) +
           int'(bus.sequencing != 0) + int'(bus.burst_done != 0) +
           int'(bus.full != 0) + int'(bus.overrun != 0);
      check(nz == 0, name, nz, 0);
   endtask

   // ---------------- monitor ----------------
   bit prev_seq = 1'b0;
   bit exp_next = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_seq = 1'b0;
            exp_next = 1'b0;
         end else begin
            if (bus.sequencing && !prev_seq) begin
               check(sq.size() != 0, "unexpected_burst_start", int'(bus.raddr), -1);
               if (sq.size() != 0) begin
                  int e;
                  e = sq.pop_front();
                  check(int'(bus.raddr) == e, "burst_start_raddr", int'(bus.raddr), e);
               end
            end
            if (!bus.sequencing)
               check(!bus.smpl_vld && bus.smpl_out == 0 && !bus.burst_done,
                     "idle_outputs_zero", int'(bus.smpl_out), 0);
            if (bus.smpl_vld) begin
               check(rq.size() != 0, "unexpected_smpl_vld", int'(bus.smpl_out), -1);
               if (rq.size() != 0) begin
                  rd_t r;
                  r = rq.pop_front();
                  check(int'(bus.smpl_out) == r.data, "smpl_out", int'(bus.smpl_out), r.data);
                  check(bus.burst_done == r.last, "burst_done_align", int'(bus.burst_done), int'(r.last));
                  exp_next = !r.last;
               end
            end else begin
               if (exp_next) check(bus.smpl_vld, "smpl_vld_gap", int'(bus.smpl_vld), 1);
               exp_next = 1'b0;
               if (bus.burst_done) check(bus.smpl_vld, "burst_done_without_vld", 0, 1);
            end
            if (bus.burst_done) done_cnt++;
            if (bus.we) begin
               check(wq.size() != 0, "unexpected_write", int'(bus.waddr), -1);
               if (wq.size() != 0) begin
                  wr_t w;
                  w = wq.pop_front();
                  check(int'(bus.waddr) == w.addr, "waddr", int'(bus.waddr), w.addr);
                  check(int'(bus.wdata) == w.data, "wdata", int'(bus.wdata), w.data);
               end
            end
            prev_seq = bus.sequencing;
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int t;
      bus.wrt_smpl = 1'b0;
      bus.new_smpl = '0;
      tb_phase = 0;
      n_acc    = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_all_zero("reset_state");

      // first four pulses: writes 2 @0 and 4 @1, not full, no burst
      for (int v = 1; v <= 4; v++) send(v, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check(!bus.full, "full_after_4_pulses", int'(bus.full), 0);

      // fill to one below TAPS, then reach TAPS
      for (int v = 5; v <= 2040; v++) send(v, 1'b1);
      check(!bus.full, "full_at_taps_minus_1", int'(bus.full), 0);
      send(2041, 1'b1);
      send(2042, 1'b1);
      check(bus.full, "full_at_taps", int'(bus.full), 1);
      wait_done("first_burst_done");
      check(rq.size() == 0, "first_burst_sample_count", rq.size(), 0);

      // five more bursts: oldest advances 1..5, write pointer and reads wrap
      for (int v = 2043; v <= 2052; v++) begin
         send(v, 1'b1);
         if (v % 2 == 0) wait_done("wrap_burst_done");
      end
      check(rq.size() == 0, "wrap_bursts_drained", rq.size(), 0);
      check(!bus.overrun, "overrun_before_inject", int'(bus.overrun), 0);

      // accepted sample ~100 cycles into a burst: written, overrun, no new burst
      send(2053, 1'b1);
      send(2054, 1'b1);
      repeat (98) @(posedge clk);
      #1;
      send(2055, 1'b1);
      send(2056, 1'b0);
      check(bus.overrun, "overrun_set", int'(bus.overrun), 1);
      wait_done("overrun_burst_done");
      repeat (1100) @(posedge clk);
      #1;
      check(rq.size() == 0 && sq.size() == 0, "overrun_no_second_burst", rq.size() + sq.size(), 0);
      check(bus.overrun, "overrun_sticky", int'(bus.overrun), 1);

      // reset roughly 500 cycles into a burst
      send(2057, 1'b1);
      send(2058, 1'b1);
      t = 0;
      while (!bus.sequencing && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      check(bus.sequencing, "reset_burst_started", int'(bus.sequencing), 1);
      repeat (498) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_all_zero("mid_burst_reset_outputs");
      rq.delete();
      sq.delete();
      wq.delete();
      tb_phase = 0;
      n_acc    = 0;
      t = done_cnt;
      repeat (5) @(posedge clk);
      #1;
      check(done_cnt == t, "no_done_after_reset", done_cnt - t, 0);

      // clean refill: identical to the first full burst
      for (int v = 1; v <= 2042; v++) send(v, 1'b1);
      check(bus.full, "full_after_refill", int'(bus.full), 1);
      wait_done("refill_burst_done");
      check(!bus.overrun, "overrun_cleared_by_reset", int'(bus.overrun), 0);

      repeat (20) @(posedge clk);
      #1;
      check(wq.size() + rq.size() + sq.size() == 0, "scoreboard_drained",
            wq.size() + rq.size() + sq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
